// File: rtl/nonce_arbiter.sv
// nonce_arbiter: collects golden nonces from NUM_MINERS miner cores, arbitrates
// them round-robin into a result FIFO and presents the FIFO head to the uplink.
// Optional build macro NONCE_ARB_EXHAUST_TRACK_EN: a captured all-zero nonce marks
// its miner as exhausted instead of being queued; need_work rises once every
// miner is exhausted. Without the macro zero nonces are ordinary results and
// need_work is held low.

// Per-miner capture slot: IDLE -> WAIT (pulse seen) -> PEND (nonce held) -> IDLE.
module nonce_capture #(
  parameter bit EXH_EN = 1'b0
) (
  input  logic        hash_clk,
  input  logic        reset_n,
  input  logic        golden_vld,
  input  logic [31:0] golden_nonce,
  input  logic        work_load,
  input  logic        grant,
  output logic        pending,
  output logic [31:0] nonce,
  output logic        ovf,
  output logic        exhausted
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PEND} state_e;

  state_e      state_q, state_d;
  logic [31:0] nonce_q, nonce_d;
  logic        exh_q, exh_d;

  // Next-state: work_load wins over everything, a pulse on a busy slot is a loss.
  always_comb begin
    state_d = state_q;
    nonce_d = nonce_q;
    exh_d   = exh_q;
    ovf     = 1'b0;
    if (work_load) begin
      state_d = S_IDLE;
      exh_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (golden_vld) state_d = S_WAIT;
        S_WAIT: begin
          // Nonce is on the bus one cycle after the pulse; capture it now.
          nonce_d = golden_nonce;
          if (golden_vld) begin
            // A newer result arrived; recapture it next edge.
            ovf = 1'b1;
          end else if (EXH_EN && golden_nonce == 32'h0) begin
            state_d = S_IDLE;
            exh_d   = 1'b1;
          end else begin
            state_d = S_PEND;
          end
        end
        S_PEND: begin
          if (golden_vld) begin
            // Held nonce is superseded; the newer one is captured next edge.
            ovf     = 1'b1;
            state_d = S_WAIT;
          end else if (grant) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Slot state registers.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      nonce_q <= 32'h0;
      exh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nonce_q <= nonce_d;
      exh_q   <= exh_d;
    end
  end

  assign pending   = (state_q == S_PEND);
  assign nonce     = nonce_q;
  assign exhausted = exh_q;

endmodule

module nonce_arbiter #(
  parameter int NUM_MINERS = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    hash_clk,
  input  logic                    reset_n,
  input  logic [NUM_MINERS-1:0]   golden_vld,
  input  logic [32*NUM_MINERS-1:0] golden_nonce,
  input  logic                    work_load,
  output logic                    tx_valid,
  output logic [39:0]             tx_data,
  input  logic                    tx_ready,
  output logic                    need_work,
  output logic                    overflow
);

`ifdef NONCE_ARB_EXHAUST_TRACK_EN
  localparam bit EXH_EN = 1'b1;
`else
  localparam bit EXH_EN = 1'b0;
`endif

  localparam int IW = (NUM_MINERS > 1) ? $clog2(NUM_MINERS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [NUM_MINERS-1:0]        pend;
  logic [NUM_MINERS-1:0][31:0]  slot_nonce;
  logic [NUM_MINERS-1:0]        slot_ovf;
  logic [NUM_MINERS-1:0]        exh;
  logic [NUM_MINERS-1:0]        grant;

  logic                         gnt_vld;
  logic [IW-1:0]                gnt_idx;
  logic [IW-1:0]                rr_ptr_q, rr_ptr_d;

  logic [FIFO_DEPTH-1:0][39:0]  mem_q, mem_d;
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [AW:0]                  cnt_q, cnt_d;
  logic                         overflow_q, overflow_d;

  logic                         full;
  logic                         pop;
  logic [39:0]                  push_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MINERS; gi++) begin : g_slot
      nonce_capture #(.EXH_EN(EXH_EN)) u_slot (
        .hash_clk     (hash_clk),
        .reset_n      (reset_n),
        .golden_vld   (golden_vld[gi]),
        .golden_nonce (golden_nonce[32*gi +: 32]),
        .work_load    (work_load),
        .grant        (grant[gi]),
        .pending      (pend[gi]),
        .nonce        (slot_nonce[gi]),
        .ovf          (slot_ovf[gi]),
        .exhausted    (exh[gi])
      );
    end
  endgenerate

  assign tx_valid = (cnt_q != '0);
  assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop      = tx_valid && tx_ready;
  assign tx_data  = mem_q[rd_ptr_q];

  // Round-robin grant: search from rr_ptr, only if the FIFO can take an entry
  // this edge; work_load discards every slot so nothing is granted then.
  always_comb begin
    int j;
    j        = 0;
    grant    = '0;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    rr_ptr_d = rr_ptr_q;
    if (!work_load && (!full || pop)) begin
      for (int k = 0; k < NUM_MINERS; k++) begin
        j = int'(rr_ptr_q) + k;
        if (j >= NUM_MINERS) j = j - NUM_MINERS;
        if (!gnt_vld && pend[j]) begin
          gnt_vld = 1'b1;
          gnt_idx = IW'(j);
        end
      end
    end
    if (gnt_vld) begin
      grant[gnt_idx] = 1'b1;
      rr_ptr_d = (gnt_idx == IW'(NUM_MINERS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign push_data = {{(8-IW){1'b0}}, gnt_idx, slot_nonce[gnt_idx]};

  // FIFO bookkeeping: pointers wrap at FIFO_DEPTH, count tracks push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (gnt_vld) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({gnt_vld, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    overflow_d = overflow_q | (|slot_ovf);
  end

  // FIFO, pointer and sticky-flag registers.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign need_work = EXH_EN & (&exh);

endmodule

// File: doc/nonce_arbiter.md
NONCE_ARBITER -- requirements
Module: nonce_arbiter

Interface
REQ-001 SHALL have parameter NUM_MINERS, default 4, number of miner cores served (legal range 1..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, result FIFO entries (power of two, 2..64).
REQ-003 SHALL have port hash_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port golden_vld  input  NUM_MINERS  per-miner one-cycle result pulse (miner is_golden).
REQ-006 SHALL have port golden_nonce  input  32*NUM_MINERS  per-miner nonce; miner i occupies bits [32i+31:32i], valid one cycle after its pulse.
REQ-007 SHALL have port work_load  input  1  one-cycle pulse: new work delivered to all miners (rx_done).
REQ-008 SHALL have port tx_valid  output  1  result available to uplink.
REQ-009 SHALL have port tx_data  output  40  {miner index[7:0], nonce[31:0]}.
REQ-010 SHALL have port tx_ready  input  1  uplink accepts tx_data this cycle.
REQ-011 SHALL have port need_work  output  1  all miners exhausted their nonce range.
REQ-012 SHALL have port overflow  output  1  sticky: a result was lost.

Function
REQ-013 Each miner SHALL have a capture FSM: IDLE -> WAIT (golden_vld[i] high) -> PENDING (nonce registered on next edge) -> IDLE (granted into FIFO).
REQ-014 A golden_vld[i] pulse in WAIT or PENDING SHALL set overflow; in PENDING the slot nonce SHALL be replaced by the newer one on its capture edge.
REQ-015 Round-robin arbiter SHALL grant at most one PENDING slot per cycle, starting search at index (last grant + 1) mod NUM_MINERS; pointer SHALL advance only on grant.
REQ-016 Grant SHALL occur only when FIFO not full, or full with a pop in the same cycle.
REQ-017 A pulse at edge E0, no contention, empty FIFO: nonce captured E1, FIFO write E2, tx_valid high after E2.
REQ-018 tx_valid SHALL equal FIFO non-empty; tx_data SHALL be the head entry and remain stable while tx_valid && !tx_ready.
REQ-019 Pop SHALL occur on an edge with tx_valid && tx_ready; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-021 work_load SHALL return all capture FSMs to IDLE (discarding WAIT/PENDING slots) and clear exhaustion state; FIFO contents and overflow SHALL be retained.
REQ-022 work_load coincident with a golden_vld pulse SHALL discard that pulse.

Reset
REQ-023 reset_n low SHALL asynchronously clear: capture FSMs to IDLE, FIFO empty, RR pointer 0, tx_valid 0, tx_data 0, need_work 0, overflow 0.
REQ-024 Reset deassertion mid-operation SHALL resume from cleared state; no partial result SHALL be emitted.

Configuration
REQ-025 Macro NONCE_ARB_EXHAUST_TRACK_EN defined: a captured nonce of 32'h00000000 SHALL set miner's exhausted flag and not be queued; need_work SHALL be high while all NUM_MINERS flags set, until work_load or reset.
REQ-026 Macro undefined: zero nonces SHALL be queued like any other result; need_work SHALL be tied 0.

Verification
REQ-027 Single pulse miner 2, nonce 32'h1D5A0C3B, tx_ready=1 -> tx_valid 2 cycles after pulse, tx_data 40'h02_1D5A0C3B, one beat.
REQ-028 Pulses on miners 0..3 same cycle, tx_ready=1 -> four beats ordered index 0,1,2,3; second burst after grant to 3 starts at 0.
REQ-029 tx_ready=0, 9 results with FIFO_DEPTH=8 -> 8 queued, ninth held PENDING, overflow stays 0; tx_ready=1 drains all 9 in order.
REQ-030 Two pulses miner 1 while PENDING and FIFO full -> overflow=1, later nonce delivered, earlier lost.
REQ-031 With NONCE_ARB_EXHAUST_TRACK_EN, zero nonce from all 4 miners -> need_work=1, no tx beats; work_load -> need_work=0 next cycle.
REQ-032 reset_n low with 3 entries queued and tx_valid high -> tx_valid=0 immediately, no beats after release.
